spi_master_gen: RTL and testbench
=================================

# spi_master_gen

Parametrised SPI master for the I2C-to-SPI bridge, driven by the same 8-bit address/data register bus as the existing single-mode master. It adds a programmable clock divider, all four SPI modes (CPOL/CPHA), MSB/LSB-first ordering, variable frame length up to DATA_W bits, and NUM_CS one-hot chip selects with optional CS hold for multi-frame bursts. A done flag reports transfer completion, and an optional interrupt output is available.

## Interface
- DATA_W, 16: maximum frame length in bits; must be a multiple of 8 and ≤ 32.
- NUM_CS, 4: number of chip-select outputs (1..8).
- i_ck  in  1  system clock.
- i_rstn  in  1  reset, asynchronous, active-low.
- i_address  in  4  register address.
- i_data  in  8  write data.
- i_wr  in  1  write strobe, one i_ck cycle per write.
- i_rd  in  1  read strobe, one i_ck cycle per read.
- o_data  out  8  read data, registered.
- o_sclk  out  1  SPI clock.
- o_csn  out  NUM_CS  chip selects, active-low.
- o_mosi  out  1  serial data out.
- i_miso  in  1  serial data in.
- o_irq  out  1  completion interrupt, level, active-high.

## Operation
- Register map:
  - 0 CTRL: b0 START, self-clears; b1 CPOL; b2 CPHA; b3 LSB_FIRST; b4 CS_HOLD; b5 IRQ_EN.
  - 1 STATUS: b0 DONE, sticky, write-1-to-clear; b1 BUSY, read-only.
  - 2 DIV: SCLK half-period is DIV+1 i_ck cycles.
  - 3 CS_SEL: b2:0 index of the chip select to assert.
  - 4 LEN: b5:0 frame bits; a value of 0 or any value > DATA_W means DATA_W.
  - 5..(5+DATA_W/8-1) TX bytes, least significant byte at address 5.
  - 9..(9+DATA_W/8-1) RX bytes, read-only, same byte order.
- Frame bits occupy TX[LEN-1:0] and RX[LEN-1:0].
  - MSB-first sends TX[LEN-1] first.
  - LSB-first sends TX[0] first.
  - RX is assembled in the same bit order, so RX holds the bits in their natural positions.
- State machine:
  - IDLE: on START=1 go to SETUP. BUSY=1, selected o_csn low, shifter loaded, first bit on o_mosi.
  - SETUP: one half-period, then go to SHIFT.
  - SHIFT: 2*LEN SCLK edges, one per half-period.
    - CPHA=0: sample on odd edges, shift on even edges (the last even edge does not shift).
    - CPHA=1: shift on odd edges, sample on even edges.
  - HOLD: one half-period, then go to DONE.
  - DONE: for one cycle, RX is loaded, DONE=1, START=0, BUSY=0. o_csn goes high unless CS_HOLD=1. Then go to IDLE.
- o_sclk idles at CPOL in every state except SHIFT.
- While BUSY, writes to CTRL, DIV, CS_SEL, LEN and TX are ignored; writes to STATUS are honoured.
- A CS_SEL value ≥ NUM_CS asserts no chip select; the frame still clocks.
- With CS_HOLD=1 the selected CS stays low across back-to-back frames. Clearing CS_HOLD while idle raises o_csn on the next cycle.
- Reads: o_data updates on the cycle after i_rd and holds its value otherwise. Unmapped addresses read 0x00.

## Timing
- Reset values:
  - o_sclk=0, o_csn=all 1, o_mosi=0, o_data=0x00, o_irq=0.
  - All registers 0, state IDLE.
- Write at cycle 0 with START=1: o_csn low at cycle 1; first SCLK edge at cycle 1+(DIV+1).
- DONE reads 1, o_csn rises and BUSY falls at cycle 1+(2*LEN+2)*(DIV+1).
- Simultaneous events:
  - DONE set and a write-1-clear in the same cycle: set wins.
  - i_wr and i_rd in the same cycle: the write executes and o_data returns the pre-write value.
- Reset asserted mid-transfer: all outputs take reset values immediately, and no partial RX is kept.

## Configuration
- SPI_IRQ_EN defined: o_irq = DONE & IRQ_EN.
- SPI_IRQ_EN undefined: o_irq is tied to 0, and CTRL b5 is not stored (reads 0).

## Test plan
- DIV=1, LEN=8, mode 0, MSB-first, TX=0xA5, MISO looped to MOSI -> 8 SCLK pulses of period 4 cycles, MOSI 1,0,1,0,0,1,0,1, RX=0xA5, DONE at cycle 1+18*2=37.
- Mode 3, LSB-first, LEN=12, TX=0x0F3C, slave model returns 0x0ABC -> MOSI sends bits 0..11 of 0x0F3C, RX=0x0ABC, SCLK idles high.
- CS_SEL=2, CS_HOLD=1, two frames -> o_csn=4'b1011 throughout both frames and between them; clearing CS_HOLD -> o_csn=4'b1111 on the next cycle.
- Write TX=0x55 and DIV=7 while BUSY -> frame unchanged; a second START after DONE uses the old DIV and TX.
- Assert i_rstn low mid-SHIFT -> o_csn=all 1, o_sclk=0, STATUS=0x00; a new transfer after reset completes normally.
- With SPI_IRQ_EN, IRQ_EN=1: o_irq rises with DONE and falls after writing STATUS=0x01. Without SPI_IRQ_EN: o_irq stays 0.

Source files
------------

// File: rtl/spi_master_gen.sv
// spi_master_gen: register-mapped SPI master with programmable SCLK divider,
// all four CPOL/CPHA modes, MSB/LSB-first order, frame length up to DATA_W
// bits and NUM_CS one-hot active-low chip selects with optional CS hold.
// Ports:
//   i_ck, i_rstn          system clock, asynchronous active-low reset
//   i_address, i_data     register address / write data
//   i_wr, i_rd, o_data    write strobe, read strobe, registered read data
//   o_sclk, o_csn         SPI clock, chip selects (active-low)
//   o_mosi, i_miso        serial data out / in
//   o_irq                 completion interrupt (DONE & IRQ_EN)
// Build option: define SPI_IRQ_EN to store CTRL.IRQ_EN and drive o_irq;
// otherwise o_irq is tied low and CTRL b5 reads 0.
module spi_master_gen #(
    parameter int DATA_W = 16,
    parameter int NUM_CS = 4
) (
    input  logic              i_ck,
    input  logic              i_rstn,
    input  logic [3:0]        i_address,
    input  logic [7:0]        i_data,
    input  logic              i_wr,
    input  logic              i_rd,
    output logic [7:0]        o_data,
    output logic              o_sclk,
    output logic [NUM_CS-1:0] o_csn,
    output logic              o_mosi,
    input  logic              i_miso,
    output logic              o_irq
);

    localparam int NB = DATA_W / 8;
    localparam logic [5:0] LEN_MAX = 6'(DATA_W);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [7:0]        div_q, cnt_q;
    logic [6:0]        edge_q, edge_n;
    logic [2:0]        cs_sel_q;
    logic [5:0]        len_q, len_eff, half, s_idx;
    logic              start_q, cpol_q, cpha_q, lsb_q, hold_q;
    logic              irq_en_q, done_q;
    logic [DATA_W-1:0] tx_q, rx_q, acc_q;
    logic [DATA_W-1:0] tx_first, tx_next, miso_w;
    logic              sclk_q, mosi_q;
    logic [NUM_CS-1:0] csn_q, sel_csn;
    logic [7:0]        data_q, rd_mux;
    logic              busy, wr_ok, wr_ctrl, start, tick;
    logic              last_edge, hold_n, cpol_n;
    logic              load, step, fin;

    // Position inside TX/RX of the j-th bit on the wire.
    function automatic logic [5:0] bit_pos(
        input logic       lsb,
        input logic [5:0] len,
        input logic [5:0] j
    );
        return lsb ? j : len - 6'd1 - j;
    endfunction

    assign busy    = (state_q == SETUP) || (state_q == SHIFT) ||
                     (state_q == HOLD);
    assign wr_ok   = i_wr && !busy;
    assign wr_ctrl = wr_ok && (i_address == 4'd0);
    assign start   = wr_ctrl && i_data[0];
    assign tick    = (cnt_q == div_q);
    assign len_eff = (len_q == 6'd0 || len_q > LEN_MAX) ? LEN_MAX : len_q;
    assign last_edge = (edge_q == {len_eff, 1'b0});
    assign edge_n  = edge_q + 7'd1;
    assign half    = edge_n[6:1];
    // CPHA=1 samples bit j on edge 2j+2, CPHA=0 on edge 2j+1.
    assign s_idx   = cpha_q ? half - 6'd1 : half;
    assign hold_n  = wr_ctrl ? i_data[4] : hold_q;
    assign cpol_n  = wr_ctrl ? i_data[1] : cpol_q;

    // LSB_FIRST arrives in the same write as START, so take it from the bus.
    assign tx_first = tx_q >> (i_data[3] ? 6'd0 : len_eff - 6'd1);
    assign tx_next  = tx_q >> bit_pos(lsb_q, len_eff, half);
    assign miso_w   = {{(DATA_W-1){1'b0}}, i_miso};

    always_comb begin
        sel_csn = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (cs_sel_q == 3'(i)) sel_csn[i] = 1'b0;
        end
    end

    always_ff @(posedge i_ck or negedge i_rstn) begin
        if (!i_rstn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        fin     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SETUP;
                    load    = 1'b1;
                end
            end
            SETUP: begin
                if (tick) begin
                    state_d = SHIFT;
                    step    = 1'b1;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (last_edge) state_d = HOLD;
                    else           step    = 1'b1;
                end
            end
            HOLD: begin
                if (tick) begin
                    state_d = DONE;
                    fin     = 1'b1;
                end
            end
            DONE: begin
                if (start) begin
                    state_d = SETUP;
                    load    = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Half-period timer, SCLK edges, shifter and chip selects.
    always_ff @(posedge i_ck or negedge i_rstn) begin
        if (!i_rstn) begin
            cnt_q  <= '0;
            edge_q <= '0;
            sclk_q <= 1'b0;
            mosi_q <= 1'b0;
            acc_q  <= '0;
            rx_q   <= '0;
            csn_q  <= '1;
        end else begin
            if (load || !busy) cnt_q <= '0;
            else if (tick)     cnt_q <= '0;
            else               cnt_q <= cnt_q + 8'd1;

            if (load) begin
                edge_q <= '0;
                acc_q  <= '0;
                sclk_q <= i_data[1];
                mosi_q <= tx_first[0];
            end else if (step) begin
                edge_q <= edge_n;
                sclk_q <= ~sclk_q;
                if (edge_n[0] ^ cpha_q) begin
                    acc_q <= acc_q |
                             (miso_w << bit_pos(lsb_q, len_eff, s_idx));
                end else if (edge_n != {len_eff, 1'b0}) begin
                    mosi_q <= tx_next[0];
                end
            end else if (state_q != SHIFT) begin
                sclk_q <= cpol_n;
            end

            if (fin) rx_q <= acc_q;

            if (load)
                csn_q <= sel_csn;
            else if ((fin && !hold_q) || (!busy && !hold_n))
                csn_q <= '1;
        end
    end

    // Register file.
    always_ff @(posedge i_ck or negedge i_rstn) begin
        if (!i_rstn) begin
            start_q  <= 1'b0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            lsb_q    <= 1'b0;
            hold_q   <= 1'b0;
`ifdef SPI_IRQ_EN
            irq_en_q <= 1'b0;
`endif
            done_q   <= 1'b0;
            div_q    <= '0;
            cs_sel_q <= '0;
            len_q    <= '0;
            tx_q     <= '0;
        end else begin
            if (wr_ctrl) begin
                start_q  <= i_data[0];
                cpol_q   <= i_data[1];
                cpha_q   <= i_data[2];
                lsb_q    <= i_data[3];
                hold_q   <= i_data[4];
`ifdef SPI_IRQ_EN
                irq_en_q <= i_data[5];
`endif
            end else if (fin) begin
                start_q <= 1'b0;
            end

            // A completing frame wins over a same-cycle clear.
            if (fin)
                done_q <= 1'b1;
            else if (i_wr && i_address == 4'd1 && i_data[0])
                done_q <= 1'b0;

            if (wr_ok && i_address == 4'd2) div_q    <= i_data;
            if (wr_ok && i_address == 4'd3) cs_sel_q <= i_data[2:0];
            if (wr_ok && i_address == 4'd4) len_q    <= i_data[5:0];
            for (int b = 0; b < NB; b++) begin
                if (wr_ok && i_address == 4'(5 + b))
                    tx_q[8*b +: 8] <= i_data;
            end
        end
    end

`ifndef SPI_IRQ_EN
    assign irq_en_q = 1'b0;
`endif

    always_comb begin
        rd_mux = 8'h00;
        case (i_address)
            4'd0: rd_mux = {2'b00, irq_en_q, hold_q, lsb_q,
                            cpha_q, cpol_q, start_q};
            4'd1: rd_mux = {6'd0, busy, done_q};
            4'd2: rd_mux = div_q;
            4'd3: rd_mux = {5'd0, cs_sel_q};
            4'd4: rd_mux = {2'b00, len_q};
            default: rd_mux = 8'h00;
        endcase
        for (int b = 0; b < NB; b++) begin
            if (i_address == 4'(5 + b)) rd_mux = tx_q[8*b +: 8];
            if (i_address == 4'(9 + b)) rd_mux = rx_q[8*b +: 8];
        end
    end

    // Registers hold pre-write values, so a same-cycle write is not seen.
    always_ff @(posedge i_ck or negedge i_rstn) begin
        if (!i_rstn)   data_q <= 8'h00;
        else if (i_rd) data_q <= rd_mux;
    end

    assign o_data = data_q;
    assign o_sclk = sclk_q;
    assign o_csn  = csn_q;
    assign o_mosi = mosi_q;
`ifdef SPI_IRQ_EN
    assign o_irq  = done_q & irq_en_q;
`else
    assign o_irq  = 1'b0;
`endif

endmodule

// File: tb/tb_spi_master_gen.sv
// tb_spi_master_gen: randomized and directed frames against an SPI slave
// model and a frame-level timing/data reference.
module tb_spi_master_gen;

    localparam int DATA_W = 16;
    localparam int NUM_CS = 4;
    localparam int NB     = DATA_W / 8;
`ifdef SPI_IRQ_EN
    localparam bit IRQ_BUILT = 1'b1;
`else
    localparam bit IRQ_BUILT = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic [3:0]        i_address = '0;
    logic [7:0]        i_data = '0;
    logic              i_wr = 1'b0;
    logic              i_rd = 1'b0;
    logic [7:0]        o_data;
    logic              o_sclk;
    logic [NUM_CS-1:0] o_csn;
    logic              o_mosi;
    logic              i_miso = 1'b0;
    logic              o_irq;

    int n_err = 0;
    int n_chk = 0;

    spi_master_gen #(.DATA_W(DATA_W), .NUM_CS(NUM_CS)) dut (
        .i_ck      (clk),
        .i_rstn    (rstn),
        .i_address (i_address),
        .i_data    (i_data),
        .i_wr      (i_wr),
        .i_rd      (i_rd),
        .o_data    (o_data),
        .o_sclk    (o_sclk),
        .o_csn     (o_csn),
        .o_mosi    (o_mosi),
        .i_miso    (i_miso),
        .o_irq     (o_irq)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        i_address = a;
        i_data    = d;
        i_wr      = 1'b1;
        @(negedge clk);
        i_wr      = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [7:0] d);
        i_address = a;
        i_rd      = 1'b1;
        @(negedge clk);
        i_rd      = 1'b0;
        d         = o_data;
    endtask

    // One complete frame: optional register setup, START, then a cycle-by-
    // cycle watch of CS/SCLK while acting as the slave, then readback.
    task automatic run_frame(input bit cpol, input bit cpha, input bit lsb,
                             input bit hold, input bit ien, input int div,
                             input int len_reg, input logic [31:0] tx,
                             input logic [31:0] sd, input int sel,
                             input bit cfg, input bit inject);
        int L, h, T, ecnt, ev, od, first, last, sp_err, cs_err, p;
        bit prev, odd;
        bit sb[32];
        logic mq[$];
        logic [31:0] mask, mword, tmp;
        logic [7:0] d;
        logic [NUM_CS-1:0] selpat, ones, expc;

        L = (len_reg == 0 || len_reg > DATA_W) ? DATA_W : len_reg;
        h = div + 1;
        T = 1 + (2 * L + 2) * h;
        mask = (L == 32) ? 32'hFFFF_FFFF : ((32'd1 << L) - 32'd1);
        for (int j = 0; j < L; j++) begin
            p = lsb ? j : L - 1 - j;
            tmp = sd >> p;
            sb[j] = tmp[0];
        end
        ones = '1;
        selpat = ones;
        if (sel < NUM_CS) selpat = ~(NUM_CS'(1) << sel);

        if (cfg) begin
            wr(4'd2, 8'(div));
            wr(4'd3, 8'(sel));
            wr(4'd4, 8'(len_reg));
            for (int b = 0; b < NB; b++) wr(4'(5 + b), 8'(tx >> (8 * b)));
        end
        i_miso = sb[0];
        wr(4'd0, {2'b00, ien, hold, lsb, cpha, cpol, 1'b1});

        ecnt = 0; ev = 0; od = 0; first = 0; last = 0;
        sp_err = 0; cs_err = 0; prev = cpol;
        for (int n = 1; n <= T + 3; n++) begin
            expc = (hold || n < T) ? selpat : ones;
            if (o_csn !== expc) cs_err++;
            if (o_sclk !== prev) begin
                prev = o_sclk;
                ecnt++;
                if (ecnt == 1) first = n;
                else if (n - last != h) sp_err++;
                last = n;
                odd = (ecnt % 2) == 1;
                if (odd ^ cpha) begin
                    mq.push_back(o_mosi);
                end else if (cpha) begin
                    if (od < L) i_miso = sb[od];
                    od++;
                end else begin
                    ev++;
                    if (ev < L) i_miso = sb[ev];
                end
            end
            if (inject && n == 4) begin
                i_address = 4'd5; i_data = 8'h55; i_wr = 1'b1;
            end else if (inject && n == 5) begin
                i_address = 4'd2; i_data = 8'd7;
            end else if (inject && n == 6) begin
                i_wr = 1'b0;
            end
            @(negedge clk);
        end

        check("edges", ecnt, 2 * L);
        check("first_edge", first, 1 + h);
        check("edge_spacing", sp_err, 0);
        check("csn_timing", cs_err, 0);
        check("mosi_count", mq.size(), L);
        mword = '0;
        for (int j = 0; j < L && j < mq.size(); j++) begin
            p = lsb ? j : L - 1 - j;
            if (mq[j] === 1'b1) mword = mword | (32'd1 << p);
        end
        check("mosi_word", mword, tx & mask);
        check("sclk_idle", o_sclk, cpol);
        check("irq_done", o_irq, ien & IRQ_BUILT);
        rd(4'd1, d);
        check("status_done", d, 8'h01);
        rd(4'd0, d);
        check("ctrl_rb", d, {2'b00, ien & IRQ_BUILT, hold, lsb, cpha, cpol,
                             1'b0});
        for (int b = 0; b < NB; b++) begin
            rd(4'(9 + b), d);
            check("rx_byte", d, 8'((sd & mask) >> (8 * b)));
        end
        wr(4'd1, 8'h01);
        check("irq_clr", o_irq, 1'b0);
        rd(4'd1, d);
        check("status_clr", d, 8'h00);
    endtask

    logic [7:0] d;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_sclk", o_sclk, 1'b0);
        check("rst_csn", o_csn, 4'hF);
        check("rst_mosi", o_mosi, 1'b0);
        check("rst_data", o_data, 8'h00);
        check("rst_irq", o_irq, 1'b0);
        rstn = 1'b1;
        @(negedge clk);
        rd(4'd1, d);
        check("rst_status", d, 8'h00);

        // Mode 0, MSB-first, slave echoes the TX pattern.
        run_frame(0, 0, 0, 0, 1, 1, 8, 32'hA5, 32'hA5, 0, 1, 0);
        // Mode 3, LSB-first, 12-bit frame.
        run_frame(1, 1, 1, 0, 0, 2, 12, 32'h0F3C, 32'h0ABC, 1, 1, 0);

        // CS hold across two frames, then release.
        run_frame(0, 0, 0, 1, 0, 0, 8, 32'h3C, 32'h96, 2, 1, 0);
        check("hold_gap", o_csn, 4'b1011);
        run_frame(0, 1, 0, 1, 1, 0, 8, 32'hC3, 32'h69, 2, 1, 0);
        check("hold_after", o_csn, 4'b1011);
        wr(4'd0, 8'h00);
        check("hold_release", o_csn, 4'b1111);

        // Config writes during BUSY are dropped.
        run_frame(0, 0, 0, 0, 0, 1, 8, 32'hA5, 32'h5A, 1, 1, 1);
        rd(4'd2, d);
        check("div_kept", d, 8'd1);
        rd(4'd5, d);
        check("tx_kept", d, 8'hA5);
        run_frame(0, 0, 0, 0, 0, 1, 8, 32'hA5, 32'h33, 1, 0, 0);

        // Same-cycle read and write return the old value.
        i_address = 4'd2; i_data = 8'd3; i_wr = 1'b1; i_rd = 1'b1;
        @(negedge clk);
        i_wr = 1'b0; i_rd = 1'b0;
        check("rdwr_old", o_data, 8'd1);
        rd(4'd2, d);
        check("rdwr_new", d, 8'd3);
        rd(4'd15, d);
        check("unmapped", d, 8'h00);

        // Reset in the middle of SHIFT.
        wr(4'd2, 8'd1);
        wr(4'd3, 8'd0);
        wr(4'd4, 8'd8);
        wr(4'd5, 8'hFF);
        i_miso = 1'b1;
        wr(4'd0, 8'h01);
        repeat (8) @(negedge clk);
        rstn = 1'b0;
        #1;
        check("mid_rst_csn", o_csn, 4'hF);
        check("mid_rst_sclk", o_sclk, 1'b0);
        check("mid_rst_mosi", o_mosi, 1'b0);
        check("mid_rst_irq", o_irq, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        rd(4'd1, d);
        check("mid_rst_status", d, 8'h00);
        rd(4'd9, d);
        check("mid_rst_rx", d, 8'h00);
        run_frame(0, 0, 0, 0, 1, 0, 8, 32'h81, 32'h7E, 3, 1, 0);

        // Randomized frames, including LEN=0 and LEN>DATA_W.
        for (int k = 0; k < 10; k++) begin
            run_frame(1'($urandom), 1'($urandom), 1'($urandom),
                      1'($urandom), 1'($urandom),
                      int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 20)),
                      32'($urandom), 32'($urandom),
                      int'($urandom_range(0, 4)), 1, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
